game_session_ctrl: RTL
======================

Name: game_session_ctrl

Overview:
Parametrised successor of the single-pair game controller. Gates an N-player game session behind authentication, sequences arm/play/pause/resume/logout from a single push-button, and routes load strobes only to the active player. Carries its own one-second tick generator and pause timers, with no external timer instance. Sits between the password-auth block and the random-number / player-register / digit-timer datapath.

Parameters:
NUM_PLAYERS, 2, number of player load channels (>=2)
TICK_CYCLES, 50000000, clk cycles per one-second tick
PAUSE_GRACE_SEC, 1, seconds in PAUSE before resume allowed; btn inside this window arms logout
PAUSE_LIMIT_SEC, 15, max seconds in RESUMABLE before forced logout
ROUND_W, 8, round counter width

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
auth_ok  in  1  level, password verified
btn  in  1  debounced single-cycle button pulse
rnd_load_in  in  1  random-number load request
player_load_in  in  NUM_PLAYERS  per-player load requests
round_timeout  in  1  digit timer expired (level)
rnd_load_out  out  1  gated random load
player_load_out  out  NUM_PLAYERS  gated player loads, at most one bit set
strt_one_sec  out  1  level, enable game one-second timer
strt_dig_timer  out  1  one-cycle pulse, restart digit timer
log_out  out  1  one-cycle pulse, session ended
active_player  out  max(1,$clog2(NUM_PLAYERS))  current player index
round_cnt  out  ROUND_W  completed rounds, saturating
state_out  out  4  current state encoding

Behaviour:
- Reset (rst=1 at posedge): state AUTH; rnd_load_out=1, player_load_out=0, strt_one_sec=0, strt_dig_timer=0, log_out=0, active_player=0, round_cnt=0, tick/second counters=0. Reset mid-operation aborts any state the same way.
- "Idle outputs" = rnd_load_out=1, player_load_out=0, strt_one_sec=0. Every state except PLAY drives idle outputs.
- All outputs registered; effects appear the cycle after the triggering edge.
- AUTH: btn & auth_ok -> ARM, pulse strt_dig_timer. btn without auth_ok is ignored.
- ARM: btn -> PLAY.
- PLAY: strt_one_sec=1; rnd_load_out=rnd_load_in; player_load_out = player_load_in masked to bit active_player. round_timeout -> ROUND_END, which has priority over btn. Otherwise btn -> PAUSE.
- Second counting: tick counter runs 0..TICK_CYCLES-1 and emits a one-cycle tick at wrap. Tick counter and second counter clear on every entry to PAUSE, RESUMABLE and LOGOUT_ARM, and count only in those states.
- PAUSE: seconds==PAUSE_GRACE_SEC -> RESUMABLE. Otherwise btn -> LOGOUT_ARM. Expiry wins over a same-cycle btn.
- RESUMABLE: btn -> PLAY; strt_one_sec reasserts the cycle after. seconds==PAUSE_LIMIT_SEC -> LOGOUT. Limit wins over a same-cycle btn.
- LOGOUT_ARM: btn -> LOGOUT. One second elapsed without btn -> ROUND_END. Expiry wins over a same-cycle btn.
- ROUND_END: on entry, round_cnt += 1, saturating at all-ones. active_player advances by 1 and wraps from NUM_PLAYERS-1 to 0. btn -> RESTART, pulse strt_dig_timer.
- RESTART: btn -> PLAY.
- LOGOUT: single cycle; pulse log_out; clear round_cnt and active_player; -> AUTH unconditionally.
- Unused encodings -> AUTH with reset output values.
- strt_dig_timer and log_out are never high for two consecutive cycles.
- round_timeout is ignored outside PLAY.

Decomposition:
- Package game_pkg holds: state encodings AUTH=0 … LOGOUT=7 as a 4-bit typedef (state_out carries the same values), the idle-output constant, and a player-index width function.
- One sub-module, sec_tick_timer:
  - Parameter TICK_CYCLES.
  - Inputs clr and en; outputs tick and seconds.
  - Instantiated once.
- FSM and output registers stay in the top.

Test Plan:
- Run with TICK_CYCLES=10 throughout.
- Login and play: rst, then auth_ok=1 and btn -> strt_dig_timer pulses once and state=ARM. Next btn -> PLAY with strt_one_sec=1. With player_load_in=2'b11 and active_player=0, player_load_out=2'b01.
- Timeout rotation: in PLAY, assert round_timeout together with btn -> ROUND_END (timeout wins), round_cnt=1, active_player=1. btn then btn -> PLAY, player_load_out follows bit 1 only. A further round wraps active_player to 0.
- Pause/resume: btn in PLAY -> PAUSE with idle outputs. After 10 cycles -> RESUMABLE. btn -> PLAY, strt_one_sec=1.
- Pause logout: btn in PLAY, btn after 3 cycles -> LOGOUT_ARM. btn -> log_out pulses 1 cycle, then AUTH, round_cnt=0.
- Forced logout: stay in RESUMABLE 150 cycles with PAUSE_LIMIT_SEC=15 -> log_out pulse. Separately, LOGOUT_ARM idle for 10 cycles -> ROUND_END.
- Reset mid-PLAY: rst=1 for one cycle -> next cycle state=AUTH, rnd_load_out=1, all other outputs 0. Saturation check with ROUND_W=2: four rounds leave round_cnt=3.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encoding, idle-output constant and sizing helper for the
// game session controller.
package game_pkg;

    typedef enum logic [3:0] {
        AUTH       = 4'd0,
        ARM        = 4'd1,
        PLAY       = 4'd2,
        PAUSE      = 4'd3,
        RESUMABLE  = 4'd4,
        LOGOUT_ARM = 4'd5,
        ROUND_END  = 4'd6,
        LOGOUT     = 4'd7,
        RESTART    = 4'd8
    } state_t;

    localparam int SEC_W = 8;

    // {rnd_load_out, strt_one_sec} whenever the session is not in PLAY
    localparam logic [1:0] IDLE_OUT = 2'b10;

    function automatic int player_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_session_ctrl_sec_tick_timer.sv
// Free-running one-second tick divider with a seconds counter; only advances
// while enabled and restarts from zero on clr.
module sec_tick_timer
    import game_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic             tick,
    output logic [SEC_W-1:0] seconds
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt     <= '0;
            seconds <= '0;
        end else if (en) begin
            if (tick) begin
                cnt     <= '0;
                seconds <= seconds + SEC_W'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/game_session_ctrl.sv
// N-player session controller: gates play behind authentication, sequences
// the session from one button and routes load strobes to the active player.
module game_session_ctrl
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int TICK_CYCLES     = 50000000,
    parameter int PAUSE_GRACE_SEC = 1,
    parameter int PAUSE_LIMIT_SEC = 15,
    parameter int ROUND_W         = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   auth_ok,
    input  logic                                   btn,
    input  logic                                   rnd_load_in,
    input  logic [NUM_PLAYERS-1:0]                 player_load_in,
    input  logic                                   round_timeout,
    output logic                                   rnd_load_out,
    output logic [NUM_PLAYERS-1:0]                 player_load_out,
    output logic                                   strt_one_sec,
    output logic                                   strt_dig_timer,
    output logic                                   log_out,
    output logic [player_idx_w(NUM_PLAYERS)-1:0]   active_player,
    output logic [ROUND_W-1:0]                     round_cnt,
    output logic [3:0]                             state_out
);

    localparam int PW = player_idx_w(NUM_PLAYERS);
    localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

    state_t           state, next_state;
    logic             bad_state;
    logic             tick, timer_clr, timer_en;
    logic [SEC_W-1:0] seconds;

    function automatic logic counting(input state_t s);
        return (s == PAUSE) || (s == RESUMABLE) || (s == LOGOUT_ARM);
    endfunction

    // True on the cycle whose tick completes the given number of seconds
    function automatic logic secs_reached(input logic t, input logic [SEC_W-1:0] s,
                                          input int limit);
        return t && (s == SEC_W'(limit - 1));
    endfunction

    assign timer_en  = counting(state);
    assign timer_clr = counting(next_state) && (next_state != state);
    assign state_out = state;

    sec_tick_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_sec_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .tick   (tick),
        .seconds(seconds)
    );

    always_comb begin
        next_state = state;
        bad_state  = 1'b0;
        case (state)
            AUTH:       if (btn && auth_ok) next_state = ARM;
            ARM:        if (btn) next_state = PLAY;
            PLAY: begin
                if (round_timeout) next_state = ROUND_END;
                else if (btn)      next_state = PAUSE;
            end
            PAUSE: begin
                if (secs_reached(tick, seconds, PAUSE_GRACE_SEC)) next_state = RESUMABLE;
                else if (btn)                                     next_state = LOGOUT_ARM;
            end
            RESUMABLE: begin
                if (secs_reached(tick, seconds, PAUSE_LIMIT_SEC)) next_state = LOGOUT;
                else if (btn)                                     next_state = PLAY;
            end
            LOGOUT_ARM: begin
                if (secs_reached(tick, seconds, 1)) next_state = ROUND_END;
                else if (btn)                       next_state = LOGOUT;
            end
            ROUND_END:  if (btn) next_state = RESTART;
            RESTART:    if (btn) next_state = PLAY;
            LOGOUT:     next_state = AUTH;
            default: begin
                next_state = AUTH;
                bad_state  = 1'b1;
            end
        endcase
    end

    // Outputs are registered from next_state so they line up with the state change
    always_ff @(posedge clk) begin
        if (rst) begin
            state                         <= AUTH;
            {rnd_load_out, strt_one_sec}  <= IDLE_OUT;
            player_load_out               <= '0;
            strt_dig_timer                <= 1'b0;
            log_out                       <= 1'b0;
            active_player                 <= '0;
            round_cnt                     <= '0;
        end else begin
            state          <= next_state;
            strt_dig_timer <= ((state == AUTH) && (next_state == ARM)) ||
                              ((state == ROUND_END) && (next_state == RESTART));
            log_out        <= (next_state == LOGOUT);

            if (next_state == PLAY) begin
                rnd_load_out    <= rnd_load_in;
                strt_one_sec    <= 1'b1;
                player_load_out <= player_load_in & (NUM_PLAYERS'(1) << active_player);
            end else begin
                {rnd_load_out, strt_one_sec} <= IDLE_OUT;
                player_load_out              <= '0;
            end

            if ((next_state == LOGOUT) || bad_state) begin
                round_cnt     <= '0;
                active_player <= '0;
            end else if ((next_state == ROUND_END) && (state != ROUND_END)) begin
                round_cnt     <= (round_cnt == '1) ? round_cnt : round_cnt + ROUND_W'(1);
                active_player <= (active_player == LAST_PLAYER) ? '0 : active_player + PW'(1);
            end
        end
    end

endmodule
